// File: rtl/serial_adder_subtractor.sv
// Bit-serial two's-complement adder/subtractor: one full adder, LSB first.
// Latency: done pulses WIDTH clocks after start is accepted; WIDTH+2 clocks between accepted starts.
// Backpressure: start is only sampled in IDLE; start while busy is ignored.
module serial_adder_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ANSWER,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_nxt;

    // One-bit full adder over the current LSBs plus the running carry
    always_comb begin
        sum_bit   = op_a[0] ^ op_b[0] ^ carry;
        carry_nxt = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        last_bit  = (cnt == LAST_BIT);
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the MSB, DONE lasts one cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Datapath: operand capture, serial shift, and result/flag update on the final bit
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            ANSWER    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: the +1 enters as the initial carry
                        op_a  <= A;
                        op_b  <= S ? ~B : B;
                        carry <= S;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= {sum_bit, res[WIDTH-1:1]};
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        // On the MSB bit the carry register holds the carry into the MSB,
                        // so it serves directly as cin_msb for the overflow flag
                        ANSWER    <= {sum_bit, res[WIDTH-1:1]};
                        carry_out <= carry_nxt;
                        overflow  <= carry ^ carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Scoreboard bench for serial_adder_subtractor: stimulus pushes expectations, monitor checks on done.
// Latency of each result is checked against the expected done cycle.
// Unexpected done pulses and output changes outside done are flagged.
module tb_serial_adder_subtractor;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         busy;
    logic         done;
    logic [W-1:0] answer;
    logic         carry_out;
    logic         overflow;

    typedef struct {
        logic [W-1:0] ans;
        logic         co;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_q = 1'b0;

    serial_adder_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (a),
        .B         (b),
        .S         (s),
        .busy      (busy),
        .done      (done),
        .ANSWER    (answer),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: checks results on done, pulse shape after done, and output stability otherwise
    logic [W-1:0] held_ans = '0;
    logic         held_co  = 1'b0;
    logic         held_ov  = 1'b0;
    logic         prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            check("reset_outputs", {busy, done, answer, carry_out, overflow}, 0);
            held_ans  = '0;
            held_co   = 1'b0;
            held_ov   = 1'b0;
            prev_done = 1'b0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("answer", answer, e.ans);
                check("carry_out", carry_out, e.co);
                check("overflow", overflow, e.ov);
                check("done_cycle", cyc, e.cyc);
                check("busy_with_done", busy, 1);
            end
            held_ans  = answer;
            held_co   = carry_out;
            held_ov   = overflow;
            prev_done = 1'b1;
        end else begin
            if (prev_done) check("after_done_busy_done", {busy, done}, 0);
            check("outputs_stable", {answer, carry_out, overflow}, {held_ans, held_co, held_ov});
            prev_done = 1'b0;
        end
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        exp_t         r;
        logic [W-1:0] yy;
        logic [W:0]   sum;
        yy    = sub ? ~y : y;
        sum   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sub};
        r.ans = sum[W-1:0];
        r.co  = sum[W];
        r.ov  = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
        r.cyc = 0;
        return r;
    endfunction

    // Drive one start at the current negedge; accepted at the next edge, done WIDTH edges later
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                          input logic [W-1:0] ea, input logic eco, input logic eov);
        exp_t e;
        a = x; b = y; s = sub; start = 1'b1;
        e.ans = ea; e.co = eco; e.ov = eov; e.cyc = cyc + 1 + W;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~x; b = ~y; s = ~sub;
        check("busy_after_start", busy, 1);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                         input logic [W-1:0] ea, input logic eco, input logic eov);
        launch(x, y, sub, ea, eco, eov);
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        exp_t m;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; s = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results
        issue(6'd10, 6'd57, 1'b1, 6'b010001, 1'b0, 1'b0);
        issue(6'd25, 6'd7,  1'b0, 6'b100000, 1'b0, 1'b1);
        issue(6'd63, 6'd1,  1'b0, 6'b000000, 1'b1, 1'b0);
        issue(6'd32, 6'd1,  1'b1, 6'b011111, 1'b1, 1'b1);
        issue(6'd5,  6'd5,  1'b1, 6'b000000, 1'b1, 1'b0);

        // Start pulse and operand changes mid-operation must be ignored
        launch(6'd10, 6'd57, 1'b1, 6'b010001, 1'b0, 1'b0);
        @(negedge clk);
        a = 6'd1; b = 6'd2; s = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 6'd44; b = 6'd13;
        repeat (W - 1) @(negedge clk);

        // Reset at clock 3 of an operation: no done, outputs cleared
        a = 6'd20; b = 6'd9; s = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 2) @(negedge clk);
        issue(6'd3, 6'd4, 1'b0, 6'd7, 1'b0, 1'b0);

        // Start held high: one operation every WIDTH+2 clocks
        a = 6'd9; b = 6'd4; s = 1'b1; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m.ans = 6'd5; m.co = 1'b1; m.ov = 1'b0;
            m.cyc = cyc + 1 + W + i * (W + 2);
            exp_q.push_back(m);
        end
        repeat (1 + 3 * (W + 2)) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Random operands against the parallel adder/subtractor model
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         sub;
            x   = W'($urandom_range(0, (1 << W) - 1));
            y   = W'($urandom_range(0, (1 << W) - 1));
            sub = 1'($urandom_range(0, 1));
            m   = model(x, y, sub);
            issue(x, y, sub, m.ans, m.co, m.ov);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
